// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves conditional branches and JALR in the ID stage of a 5-stage pipeline.
// Operands are taken from the register file or from the forwarding paths. A
// load still in EX (or in MEM) that feeds the branch forces a stall. A taken
// branch/JALR produces a one-cycle redirect/flush pulse in the cycle after
// the resolving cycle.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   branch_i, jalr_i    : conditional branch / JALR present in ID
//   funct3_i            : branch condition
//   pc_i, imm_i         : ID-stage PC and sign-extended immediate
//   rs1_data_i,
//   rs2_data_i          : register-file read data
//   ex_mem_data_i,
//   mem_wb_data_i       : forwarded results
//   fwd_a, fwd_b        : operand selects (00/11 RF, 01 EX/MEM, 10 MEM/WB)
//   rs1_i, rs2_i        : source register numbers
//   id_ex_mem_read_i,
//   id_ex_rd_i          : load in EX and its destination
//   ex_mem_mem_read_i,
//   ex_mem_rd_i         : load in MEM and its destination
//   stall_o             : hold IF/ID, bubble ID/EX (combinational)
//   redirect_o, flush_o : one-cycle PC redirect / IF/ID squash
//   target_o            : redirect PC (holds last registered value)
//   br_count_o,
//   br_taken_o          : resolved / taken statistics
//
// Configuration
//   BRANCH_STATS_EN     : when defined, br_count_o/br_taken_o are live
//                         wrapping counters; otherwise they are tied to 0.
// -----------------------------------------------------------------------------
module branch_resolve_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_i,
  input  logic        jalr_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] ex_mem_data_i,
  input  logic [31:0] mem_wb_data_i,
  input  logic [1:0]  fwd_a,
  input  logic [1:0]  fwd_b,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic        id_ex_mem_read_i,
  input  logic [4:0]  id_ex_rd_i,
  input  logic        ex_mem_mem_read_i,
  input  logic [4:0]  ex_mem_rd_i,
  output logic        stall_o,
  output logic        redirect_o,
  output logic        flush_o,
  output logic [31:0] target_o,
  output logic [31:0] br_count_o,
  output logic [31:0] br_taken_o
);

  typedef enum logic [1:0] {
    S_RESOLVE  = 2'd0,
    S_STALL    = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        counter_q, counter_d;
  logic [31:0] target_q, target_d;
  logic        redirect_q, redirect_d;
  logic        flush_q, flush_d;

  logic [31:0] op_a_s, op_b_s;
  logic        active_s, hazard_ex_s, hazard_mem_s;
  logic        cond_s, taken_s, resolve_s;
  logic [31:0] target_s, jalr_sum_s;

  // Operand A forwarding mux.
  always_comb begin
    op_a_s = rs1_data_i;
    case (fwd_a)
      2'b01:   op_a_s = ex_mem_data_i;
      2'b10:   op_a_s = mem_wb_data_i;
      default: op_a_s = rs1_data_i;
    endcase
  end

  // Operand B forwarding mux.
  always_comb begin
    op_b_s = rs2_data_i;
    case (fwd_b)
      2'b01:   op_b_s = ex_mem_data_i;
      2'b10:   op_b_s = mem_wb_data_i;
      default: op_b_s = rs2_data_i;
    endcase
  end

  // Load-use hazards only matter while a control-flow instruction sits in ID.
  assign active_s     = branch_i | jalr_i;
  assign hazard_ex_s  = active_s & id_ex_mem_read_i & (id_ex_rd_i != 5'd0) &
                        ((id_ex_rd_i == rs1_i) | (id_ex_rd_i == rs2_i));
  assign hazard_mem_s = active_s & ex_mem_mem_read_i & (ex_mem_rd_i != 5'd0) &
                        ((ex_mem_rd_i == rs1_i) | (ex_mem_rd_i == rs2_i));

  // Branch condition evaluation.
  always_comb begin
    cond_s = 1'b0;
    case (funct3_i)
      3'b000:  cond_s = (op_a_s == op_b_s);
      3'b001:  cond_s = (op_a_s != op_b_s);
      3'b100:  cond_s = ($signed(op_a_s) <  $signed(op_b_s));
      3'b101:  cond_s = ($signed(op_a_s) >= $signed(op_b_s));
      3'b110:  cond_s = (op_a_s <  op_b_s);
      3'b111:  cond_s = (op_a_s >= op_b_s);
      default: cond_s = 1'b0;
    endcase
  end

  assign jalr_sum_s = op_a_s + imm_i;

  // Taken decision and target; JALR wins over a simultaneous branch.
  always_comb begin
    taken_s  = 1'b0;
    target_s = 32'd0;
    if (jalr_i) begin
      taken_s  = 1'b1;
      target_s = {jalr_sum_s[31:1], 1'b0};
    end else if (branch_i) begin
      taken_s  = cond_s;
      target_s = pc_i + imm_i;
    end else begin
      taken_s  = 1'b0;
      target_s = 32'd0;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    target_d   = target_q;
    redirect_d = 1'b0;
    flush_d    = 1'b0;
    resolve_s  = 1'b0;
    case (state_q)
      S_RESOLVE: begin
        if (hazard_ex_s) begin
          counter_d = 1'b1;
          state_d   = S_STALL;
        end else if (hazard_mem_s) begin
          state_d = S_RESOLVE;
        end else if (active_s) begin
          resolve_s = 1'b1;
          if (taken_s) begin
            target_d   = target_s;
            redirect_d = 1'b1;
            flush_d    = 1'b1;
            state_d    = S_REDIRECT;
          end else begin
            state_d = S_RESOLVE;
          end
        end else begin
          state_d = S_RESOLVE;
        end
      end
      S_STALL: begin
        if (counter_q != 1'b0) begin
          counter_d = counter_q - 1'b1;
        end else begin
          counter_d = 1'b0;
        end
        if (counter_d == 1'b0) begin
          state_d = S_RESOLVE;
        end else begin
          state_d = S_STALL;
        end
      end
      S_REDIRECT: begin
        // Instruction in ID is wrong-path; it is flushed, not resolved.
        state_d = S_RESOLVE;
      end
      default: begin
        state_d   = S_RESOLVE;
        counter_d = 1'b0;
      end
    endcase
  end

  // Stall is combinational so IF/ID is held in the same cycle the hazard is seen.
  always_comb begin
    stall_o = 1'b0;
    if (rst) begin
      stall_o = 1'b0;
    end else begin
      case (state_q)
        S_RESOLVE:  stall_o = hazard_ex_s | hazard_mem_s;
        S_STALL:    stall_o = 1'b1;
        S_REDIRECT: stall_o = 1'b0;
        default:    stall_o = 1'b0;
      endcase
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RESOLVE;
      counter_q  <= 1'b0;
      target_q   <= 32'd0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
    end
  end

  assign redirect_o = redirect_q;
  assign flush_o    = flush_q;
  assign target_o   = target_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] br_taken_q, br_taken_d;

  // Statistics next values; stalled cycles never set resolve_s.
  always_comb begin
    br_count_d = br_count_q + {31'd0, resolve_s};
    br_taken_d = br_taken_q + {31'd0, resolve_s & taken_s};
  end

  // Statistics counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q <= 32'd0;
      br_taken_q <= 32'd0;
    end else begin
      br_count_q <= br_count_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_count_o = br_count_q;
  assign br_taken_o = br_taken_q;
`else
  assign br_count_o = 32'd0;
  assign br_taken_o = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_i, jalr_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i, imm_i, rs1_data_i, rs2_data_i, ex_mem_data_i, mem_wb_data_i;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  rs1_i, rs2_i, id_ex_rd_i, ex_mem_rd_i;
  logic        id_ex_mem_read_i, ex_mem_mem_read_i;
  logic        stall_o, redirect_o, flush_o;
  logic [31:0] target_o, br_count_o, br_taken_o;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: pending redirect flag, remaining forced-stall cycles,
  // last redirect target and statistics.
  bit          m_pend;
  int          m_stall_left;
  logic [31:0] m_target;
  logic [31:0] m_count, m_taken;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .branch_i(branch_i), .jalr_i(jalr_i),
    .funct3_i(funct3_i), .pc_i(pc_i), .imm_i(imm_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .ex_mem_data_i(ex_mem_data_i), .mem_wb_data_i(mem_wb_data_i),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .id_ex_mem_read_i(id_ex_mem_read_i), .id_ex_rd_i(id_ex_rd_i),
    .ex_mem_mem_read_i(ex_mem_mem_read_i), .ex_mem_rd_i(ex_mem_rd_i),
    .stall_o(stall_o), .redirect_o(redirect_o), .flush_o(flush_o),
    .target_o(target_o), .br_count_o(br_count_o), .br_taken_o(br_taken_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'd1) return ex_mem_data_i;
    if (sel == 2'd2) return mem_wb_data_i;
    return rf;
  endfunction

  // Architectural outcome of the instruction currently in ID.
  task automatic ref_eval(output bit tk, output logic [31:0] tgt);
    logic [31:0] a, b;
    a = pick(fwd_a, rs1_data_i);
    b = pick(fwd_b, rs2_data_i);
    tk = 1'b0; tgt = 32'd0;
    if (jalr_i) begin
      tk  = 1'b1;
      tgt = (a + imm_i) & 32'hFFFF_FFFE;
    end else if (branch_i) begin
      tgt = pc_i + imm_i;
      case (funct3_i)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = (int'(a) <  int'(b));
        3'd5: tk = (int'(a) >= int'(b));
        3'd6: tk = (a <  b);
        3'd7: tk = (a >= b);
        default: tk = 1'b0;
      endcase
    end
  endtask

  function automatic bit uses(input logic rd_read, input logic [4:0] rd);
    return (branch_i | jalr_i) && rd_read && rd != 5'd0 && (rd == rs1_i || rd == rs2_i);
  endfunction

  task automatic idle();
    rst = 1'b0; branch_i = 1'b0; jalr_i = 1'b0; funct3_i = 3'd0;
    pc_i = 32'd0; imm_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    ex_mem_data_i = 32'd0; mem_wb_data_i = 32'd0; fwd_a = 2'd0; fwd_b = 2'd0;
    rs1_i = 5'd0; rs2_i = 5'd0; id_ex_mem_read_i = 1'b0; id_ex_rd_i = 5'd0;
    ex_mem_mem_read_i = 1'b0; ex_mem_rd_i = 5'd0;
  endtask

  // One clock: check stall before the edge, update the model, check the rest after.
  task automatic step();
    bit          exp_stall, hz_ex, hz_mem, tk;
    logic [31:0] tgt;
    #1;
    hz_ex  = uses(id_ex_mem_read_i, id_ex_rd_i);
    hz_mem = uses(ex_mem_mem_read_i, ex_mem_rd_i);
    ref_eval(tk, tgt);
    if (rst || m_pend) exp_stall = 1'b0;
    else if (m_stall_left > 0) exp_stall = 1'b1;
    else exp_stall = hz_ex | hz_mem;
    check("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0; m_stall_left = 0; m_target = 32'd0;
      m_count = 32'd0; m_taken = 32'd0;
    end else if (m_pend) begin
      m_pend = 1'b0;
    end else if (m_stall_left > 0) begin
      m_stall_left--;
    end else if ((branch_i | jalr_i) && hz_ex) begin
      m_stall_left = 1;
    end else if ((branch_i | jalr_i) && !hz_mem) begin
      m_count++;
      if (tk) begin
        m_taken++;
        m_target = tgt;
        m_pend   = 1'b1;
      end
    end
    #1;
    check("redirect_o", {31'd0, redirect_o}, {31'd0, m_pend});
    check("flush_o", {31'd0, flush_o}, {31'd0, m_pend});
    check("target_o", target_o, m_target);
`ifdef BRANCH_STATS_EN
    check("br_count_o", br_count_o, m_count);
    check("br_taken_o", br_taken_o, m_taken);
`else
    check("br_count_o", br_count_o, 32'd0);
    check("br_taken_o", br_taken_o, 32'd0);
`endif
    @(negedge clk);
  endtask

  initial begin
    m_pend = 1'b0; m_stall_left = 0; m_target = 32'd0; m_count = 32'd0; m_taken = 32'd0;
    idle();
    @(negedge clk);

    // Reset with a hazard present: stall_o must stay low in the reset cycle.
    rst = 1'b1; branch_i = 1'b1; id_ex_mem_read_i = 1'b1; id_ex_rd_i = 5'd3; rs1_i = 5'd3;
    step();
    idle(); rst = 1'b1; step();
    check("reset_target", target_o, 32'd0);

    // BEQ taken: redirect to 0x120 for exactly one cycle.
    idle(); branch_i = 1'b1; funct3_i = 3'd0; rs1_data_i = 32'd5; rs2_data_i = 32'd5;
    pc_i = 32'h100; imm_i = 32'h20;
    step();
    check("beq_redirect", {31'd0, redirect_o}, 32'd1);
    check("beq_target", target_o, 32'h120);
    idle(); step();
    check("beq_pulse_end", {31'd0, redirect_o}, 32'd0);

    // BNE with EX/MEM forwarding, equal operands: not taken.
    idle(); branch_i = 1'b1; funct3_i = 3'd1; fwd_a = 2'd1; ex_mem_data_i = 32'd7;
    rs2_data_i = 32'd7; rs1_data_i = 32'd9;
    step();
    check("bne_not_taken", {31'd0, redirect_o}, 32'd0);

    // BLT signed taken, BLTU not taken with the same operands.
    idle(); branch_i = 1'b1; funct3_i = 3'd4; rs1_data_i = 32'hFFFF_FFFF; rs2_data_i = 32'd1;
    pc_i = 32'h200; imm_i = 32'hFFFF_FFF0;
    step();
    check("blt_taken", {31'd0, redirect_o}, 32'd1);
    check("blt_target", target_o, 32'h1F0);
    idle(); step();
    idle(); branch_i = 1'b1; funct3_i = 3'd6; rs1_data_i = 32'hFFFF_FFFF; rs2_data_i = 32'd1;
    step();
    check("bltu_not_taken", {31'd0, redirect_o}, 32'd0);

    // JALR target clears bit 0 and beats a simultaneous branch; the branch
    // arriving during REDIRECT is wrong-path and ignored.
    idle(); jalr_i = 1'b1; branch_i = 1'b1; funct3_i = 3'd2; rs1_data_i = 32'h2003;
    step();
    check("jalr_target", target_o, 32'h2002);
    idle(); branch_i = 1'b1; rs1_data_i = 32'd1; rs2_data_i = 32'd1; pc_i = 32'h4000; imm_i = 32'h8;
    step();
    check("redirect_ignores_branch", target_o, 32'h2002);
    idle(); step();
    check("after_redirect_idle", {31'd0, redirect_o}, 32'd0);

    // Load in EX feeding rs1: two stall cycles, then the branch resolves.
    idle(); branch_i = 1'b1; funct3_i = 3'd0; rs1_i = 5'd5; id_ex_mem_read_i = 1'b1;
    id_ex_rd_i = 5'd5; pc_i = 32'h300; imm_i = 32'h40;
    step(); step();
    id_ex_mem_read_i = 1'b0;
    step();
    check("stall_then_resolve", target_o, 32'h340);
    idle(); step();

    // Reset during STALL aborts it; no redirect afterwards.
    idle(); branch_i = 1'b1; rs1_i = 5'd5; id_ex_mem_read_i = 1'b1; id_ex_rd_i = 5'd5;
    step();
    rst = 1'b1; step();
    idle(); step();
    check("rst_in_stall_no_redirect", {31'd0, redirect_o}, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      branch_i = $urandom_range(0, 1);
      jalr_i = ($urandom_range(0, 3) == 0);
      funct3_i = $urandom_range(0, 7);
      pc_i = $urandom; imm_i = $urandom;
      rs1_data_i = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom;
      rs2_data_i = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 3) : $urandom;
      ex_mem_data_i = $urandom_range(0, 3); mem_wb_data_i = $urandom;
      fwd_a = $urandom_range(0, 3); fwd_b = $urandom_range(0, 3);
      rs1_i = $urandom_range(0, 7); rs2_i = $urandom_range(0, 7);
      id_ex_mem_read_i = ($urandom_range(0, 3) == 0); id_ex_rd_i = $urandom_range(0, 7);
      ex_mem_mem_read_i = ($urandom_range(0, 3) == 0); ex_mem_rd_i = $urandom_range(0, 7);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
